// File: rtl/sram_bus_if.sv
// Core-side request/response bus for the SRAM controller.
//
// Handshake: the master raises bus_req with bus_we/bus_word/bus_addr/bus_wdata
// stable. A request is accepted on the rising edge where bus_req && bus_ready.
// All request fields are sampled on that edge only. bus_req is ignored while
// bus_ready is low. Completion is a single-cycle bus_ack. bus_err qualifies
// bus_ack. bus_rdata holds the most recent completed read result.
interface sram_bus_if;
  logic        bus_req;
  logic        bus_ready;
  logic        bus_we;
  logic        bus_word;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_ack;
  logic        bus_err;
  logic [15:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_word, bus_addr, bus_wdata,
    input  bus_ready, bus_ack, bus_err, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_word, bus_addr, bus_wdata,
    output bus_ready, bus_ack, bus_err, bus_rdata
  );
endinterface

// File: rtl/sram_bus_ctrl.sv
// Bus-side controller in front of a byte-wide synchronous SRAM.
// It splits 16-bit accesses into two byte cycles, low byte first.
// SRAM read data arrives one cycle after the select, so each read byte is
// captured in the state that follows its SRAM cycle.
// Out-of-window and wrapping word accesses complete with bus_err and never
// touch the SRAM.
// dbg_state exposes the FSM state encoding.
module sram_bus_ctrl #(
  parameter int MEM_AW = 15
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  sram_bus_if.slave         bus,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              sram_cs,
  output logic              we_pin,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_CAP  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic                word_q, word_d;
  logic                err_q, err_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [15:0]         rdata_q, rdata_d;

  logic                addr_hi_err;
  logic                wrap_err;
  logic                acc_err;
  logic [MEM_AW-1:0]   addr_inc;

  // Request validation: any address bit above the window is an error. A word
  // on the last byte would need to wrap, and that is rejected too.
  always_comb begin
    addr_hi_err = |(bus.bus_addr >> MEM_AW);
    wrap_err    = bus.bus_word & (&bus.bus_addr[MEM_AW-1:0]);
    acc_err     = addr_hi_err | wrap_err;
    addr_inc    = addr_q + {{(MEM_AW-1){1'b0}}, 1'b1};
  end

  // Next-state and register updates for the transaction sequencer
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    word_d  = word_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.bus_req) begin
          we_d    = bus.bus_we;
          word_d  = bus.bus_word;
          addr_d  = bus.bus_addr[MEM_AW-1:0];
          wdata_d = bus.bus_wdata;
          err_d   = acc_err;
          state_d = acc_err ? S_RESP : S_LO;
        end
      end
      S_LO: begin
        state_d = word_q ? S_HI : S_CAP;
      end
      S_HI: begin
        // mem_rdata here is the low byte read during LO.
        if (!we_q) begin
          rdata_d[7:0] = mem_rdata;
        end
        state_d = S_CAP;
      end
      S_CAP: begin
        // mem_rdata here is the byte from the last SRAM cycle.
        if (!we_q) begin
          if (word_q) begin
            rdata_d = {mem_rdata, rdata_q[7:0]};
          end else begin
            rdata_d = {8'h00, mem_rdata};
          end
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latched request registers. An asynchronous reset aborts any
  // transaction in flight.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      word_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      word_q  <= word_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus-side outputs and SRAM pins, decoded from state and the latched fields.
  // Pins are zero outside LO/HI.
  always_comb begin
    bus.bus_ready = (state_q == S_IDLE);
    bus.bus_ack   = (state_q == S_RESP);
    bus.bus_err   = (state_q == S_RESP) & err_q;
    bus.bus_rdata = rdata_q;
    sram_cs       = 1'b0;
    we_pin        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = 8'h00;
    case (state_q)
      S_LO: begin
        sram_cs   = 1'b1;
        we_pin    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q[7:0];
      end
      S_HI: begin
        sram_cs   = 1'b1;
        we_pin    = we_q;
        mem_addr  = addr_inc;
        mem_wdata = wdata_q[15:8];
      end
      default: begin
        sram_cs = 1'b0;
      end
    endcase
    dbg_state = state_q;
  end

endmodule

// File: doc/sram_bus_ctrl.md
# sram_bus_ctrl

Bus-side controller placed directly upstream of the 32Kx8 SRAM wrapper. It accepts byte or 16-bit word requests from the core over a valid/ready handshake and splits word accesses into two byte cycles, low byte first. It drives the SRAM `mem_addr`/`sram_cs`/`we_pin`/`mem_wdata` pins, collects `mem_rdata` under the SRAM's one-cycle synchronous read latency, and returns a one-cycle `bus_ack` with read data or an error flag.

## Interface
Parameters:
- `MEM_AW`, 15: SRAM byte-address width. Window is `0 .. 2^MEM_AW-1`.

Ports:
- `clk`  in  1  single system clock, rising edge
- `sys_rst_n`  in  1  reset, asynchronous, active-low
- `bus_req`  in  1  request valid
- `bus_ready`  out  1  controller idle; request accepted on the edge where `bus_req && bus_ready`
- `bus_we`  in  1  1 = write, 0 = read; sampled at accept
- `bus_word`  in  1  1 = 16-bit access, 0 = byte; sampled at accept
- `bus_addr`  in  16  byte address; sampled at accept
- `bus_wdata`  in  16  write data; byte writes use `[7:0]`; sampled at accept
- `bus_ack`  out  1  one-cycle completion pulse
- `bus_err`  out  1  qualifies `bus_ack`: access rejected, no SRAM cycle issued
- `bus_rdata`  out  16  read result; held until the next completed read
- `mem_addr`  out  MEM_AW  SRAM address
- `sram_cs`  out  1  SRAM select, active high
- `we_pin`  out  1  SRAM write enable, active high; only meaningful with `sram_cs`
- `mem_wdata`  out  8  SRAM write byte
- `mem_rdata`  in  8  SRAM read byte; valid the cycle after a `sram_cs` read cycle

## Operation
- States: IDLE, LO, HI, CAP, RESP.
- IDLE: `bus_ready`=1. On accept, latch `we`, `word`, `addr`, `wdata`.
  - Error if `addr[15:MEM_AW]` != 0, or if `word` && `addr[MEM_AW-1:0]` == all-ones (no wrap-around). Error goes to RESP, else to LO.
- LO: `sram_cs`=1, `mem_addr`=addr, `we_pin`=we, `mem_wdata`=wdata[7:0]. Next state is HI if word, else CAP.
- HI: `sram_cs`=1, `mem_addr`=addr+1, `we_pin`=we, `mem_wdata`=wdata[15:8].
  - On a read, latch `mem_rdata` into `bus_rdata[7:0]`.
  - Next state is CAP.
- CAP: `sram_cs`=0. On a read, latch `mem_rdata`:
  - Word read: into `bus_rdata[15:8]`.
  - Byte read: `bus_rdata` = {8'h00, `mem_rdata`}.
  - Next state is RESP.
- RESP: `bus_ack`=1 and `bus_err` = the error flag. Always returns to IDLE.
- Writes never modify `bus_rdata`. Error responses leave `bus_rdata` unchanged.
- SRAM pins are decoded combinationally from state and the latched registers. Outside LO/HI, `sram_cs`=0, `we_pin`=0, `mem_addr`=0, `mem_wdata`=0.
- `bus_req` is ignored while `bus_ready`=0.

## Timing
- Accept edge is T0. Latency from T0 to the cycle in which `bus_ack`=1:
  - Byte access: 3 cycles (LO, CAP, RESP).
  - Word access: 4 cycles (LO, HI, CAP, RESP).
  - Error: 1 cycle (RESP).
- `sram_cs` is high for exactly 1 cycle on a byte access and 2 consecutive cycles on a word access.
- `bus_rdata` is valid in the `bus_ack` cycle.
- Maximum throughput: the next accept can happen in the cycle after RESP (IDLE). There is no overlap between transactions.
- Reset values: state=IDLE, `bus_ready`=1, `bus_ack`=0, `bus_err`=0, `bus_rdata`=0, and all SRAM outputs 0.
- Reset asserted mid-transaction: the transaction is aborted immediately (asynchronously).
  - `sram_cs`/`we_pin` drop in the same cycle.
  - No `bus_ack` is issued.
  - A word write interrupted in HI leaves the high byte unwritten.
- `bus_req` held high continuously: consecutive requests are accepted in each IDLE cycle.

## Test plan
- Byte write 0x5A at 0x0010, then byte read at 0x0010 -> expect:
  - `sram_cs` high for 1 cycle each time, `we_pin`=1 only on the write.
  - Read `bus_ack` at T0+3 with `bus_rdata`=0x005A and `bus_err`=0.
- Word write 0x1234 at 0x0200 -> SRAM[0x200]=0x34, SRAM[0x201]=0x12, ack at T0+4. Word read at 0x0200 -> `bus_rdata`=0x1234 at T0+4.
- Error cases, each with `bus_ack` and `bus_err`=1 at T0+1, `sram_cs` never asserted, and `bus_rdata` unchanged:
  - Read at 0x8000.
  - Word read at 0x7FFF.
  - Word write at 0xFFFE.
- Read 0x00A5, then a word write of 0xBEEF elsewhere -> `bus_rdata` still 0x00A5 after the write ack.
- Word write 0xCAFE at 0x0300 with `sys_rst_n` dropped in HI:
  - `sram_cs`=0 in the same cycle, no ack, SRAM[0x0301] keeps its old value.
  - After release, `bus_ready`=1 and all outputs are at reset values.
- `bus_req` held high over 3 byte reads -> `bus_ready` low between accepts, accepts spaced 4 cycles apart, 3 ack pulses with correct data.
